// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - multiply/divide unit op encodings, FSM states and op decodes
package e_mdu_pkg;

    // MFLO needs a ninth code, so the op field is 4 bits wide.
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int CNT_W = 16;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mdu_op(input logic [3:0] op);
        return (op != MDU_NONE) && (op <= MDU_MFLO);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - execute-stage multiply/divide unit owning HI/LO with fixed-latency busy
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);

    mdu_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      pend_hi, pend_lo;
    logic             pend_wr;
    logic             launch, finish;

    logic [63:0]      prod_s, prod_u;
    logic [31:0]      rs_mag, rt_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic [31:0]      res_hi, res_lo;
    logic             res_wr;
    logic [CNT_W-1:0] res_lat;

    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
    assign rs_mag = rs_val[31] ? -rs_val : rs_val;
    assign rt_mag = rt_val[31] ? -rt_val : rt_val;
    assign q_mag  = rs_mag / rt_mag;
    assign r_mag  = rs_mag % rt_mag;
    assign q_s    = (rs_val[31] ^ rt_val[31]) ? -q_mag : q_mag;
    assign r_s    = rs_val[31] ? -r_mag : r_mag;
    assign q_u    = rs_val / rt_val;
    assign r_u    = rs_val % rt_val;

    always_comb begin
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        res_wr  = 1'b0;
        res_lat = CNT_W'(DIV_CYCLES);
        case (mdu_op)
            MDU_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_wr  = 1'b1;
                res_lat = CNT_W'(MULT_CYCLES);
            end
            MDU_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_wr  = 1'b1;
                res_lat = CNT_W'(MULT_CYCLES);
            end
            MDU_DIV: begin
                res_hi = r_s;
                res_lo = q_s;
                res_wr = (rt_val != 32'd0);
            end
            MDU_DIVU: begin
                res_hi = r_u;
                res_lo = q_u;
                res_wr = (rt_val != 32'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        launch     = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && is_muldiv(mdu_op)) begin
                    launch     = 1'b1;
                    cnt_next   = res_lat;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (launch) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= res_wr;
            end
            // Moves to HI/LO only land while idle; a divide by zero completes without writing.
            if (state == ST_IDLE) begin
                if (mdu_op == MDU_MTHI) hi <= rs_val;
                if (mdu_op == MDU_MTLO) lo <= rs_val;
            end else if (finish && pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end
    end

    assign busy = (state == ST_RUN);

    always_comb begin
        mdu_out = 32'd0;
        if (mdu_op == MDU_MFHI) mdu_out = hi;
        else if (mdu_op == MDU_MFLO) mdu_out = lo;
    end

endmodule
